// File: rtl/qtcore_scan_pkg.sv
// Shared sizing helpers and default geometry for qtcore scan-chained memory banks.
package qtcore_scan_pkg;

  localparam int unsigned DEF_WIDTH     = 8;
  localparam int unsigned DEF_DEPTH     = 16;
  localparam int unsigned DEF_KEY_WIDTH = 16;
  localparam logic [15:0] DEF_KEY       = 16'hA5C3;

  function automatic int unsigned chain_len(input int unsigned depth, input int unsigned width,
                                            input int unsigned key_width);
    return depth * width + key_width;
  endfunction

  function automatic int unsigned addr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/qtcore_scan_mem_locked_scan_reg_cell.sv
// One scan-chain segment: serial shift toward the MSB in scan mode, parallel load otherwise.
module scan_reg_cell #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             scan_enable,
  input  logic             scan_in,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] internal_data,
  output logic             scan_out
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      internal_data <= '0;
    end else if (scan_enable) begin
      internal_data <= {internal_data[WIDTH-2:0], scan_in};
    end else if (load_en) begin
      internal_data <= load_data;
    end
  end

  assign scan_out = internal_data[WIDTH-1];

endmodule

// File: rtl/qtcore_scan_mem_locked.sv
// Scan-chained memory bank with IO register, key segment, shift counter and locked read path.
module qtcore_scan_mem_locked
  import qtcore_scan_pkg::*;
#(
  parameter int unsigned          WIDTH     = DEF_WIDTH,
  parameter int unsigned          DEPTH     = DEF_DEPTH,
  parameter int unsigned          KEY_WIDTH = DEF_KEY_WIDTH,
  parameter logic [KEY_WIDTH-1:0] KEY       = DEF_KEY,
  parameter logic [WIDTH-1:0]     LOCK_MASK = 8'h5A
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          scan_enable_in,
  input  logic                          scan_in,
  output logic                          scan_out,
  input  logic                          proc_en_in,
  input  logic [addr_width(DEPTH)-1:0]  addr_in,
  input  logic                          we_in,
  input  logic [WIDTH-1:0]              wdata_in,
  output logic [WIDTH-1:0]              rdata_out,
  input  logic                          btn_in,
  output logic [WIDTH-1:0]              io_out,
  output logic                          key_ok_out,
  output logic                          scan_done_out
);

  localparam int unsigned    AW        = addr_width(DEPTH);
  localparam int unsigned    CHAIN_LEN = chain_len(DEPTH, WIDTH, KEY_WIDTH);
  localparam int unsigned    CW        = $clog2(CHAIN_LEN);
  localparam logic [AW-1:0]  IO_ADDR   = AW'(DEPTH - 1);
  localparam bit             ADDR_FULL = (DEPTH == (1 << AW));

  logic [WIDTH-1:0]     words [DEPTH];
  logic [DEPTH:0]       chain;
  logic [KEY_WIDTH-1:0] key_reg;
  logic [CW-1:0]        shift_cnt;
  logic                 shifted;
  logic                 wr_en_c;
  logic [WIDTH-1:0]     raw_c;

  assign chain[0] = scan_in;
  assign wr_en_c  = ~scan_enable_in & proc_en_in & we_in;

  // Word i sits between chain taps i and i+1; the key segment closes the chain.
  for (genvar i = 0; i < DEPTH; i++) begin : memory
    scan_reg_cell #(.WIDTH(WIDTH)) mem_cell (
      .clk           (clk_in),
      .rst           (rst_in),
      .scan_enable   (scan_enable_in),
      .scan_in       (chain[i]),
      .load_en       (wr_en_c && (addr_in == AW'(i))),
      .load_data     (wdata_in),
      .internal_data (words[i]),
      .scan_out      (chain[i+1])
    );
  end

  scan_reg_cell #(.WIDTH(KEY_WIDTH)) key_cell (
    .clk           (clk_in),
    .rst           (rst_in),
    .scan_enable   (scan_enable_in),
    .scan_in       (chain[DEPTH]),
    .load_en       (1'b0),
    .load_data     ('0),
    .internal_data (key_reg),
    .scan_out      (scan_out)
  );

  // Shift counter, done pulse, and key check on the first idle cycle after a scan.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      shift_cnt     <= '0;
      scan_done_out <= 1'b0;
      shifted       <= 1'b0;
      key_ok_out    <= 1'b0;
    end else if (scan_enable_in) begin
      shifted <= 1'b1;
      if (shift_cnt == CW'(CHAIN_LEN - 1)) begin
        shift_cnt     <= '0;
        scan_done_out <= 1'b1;
      end else begin
        shift_cnt     <= shift_cnt + CW'(1);
        scan_done_out <= 1'b0;
      end
    end else begin
      shift_cnt     <= '0;
      scan_done_out <= 1'b0;
      shifted       <= 1'b0;
      if (shifted) key_ok_out <= (key_reg == KEY);
    end
  end

  always_comb begin
    raw_c = '0;
    if (ADDR_FULL || (int'(addr_in) < int'(DEPTH))) begin
      raw_c = words[addr_in];
      if (addr_in == IO_ADDR) raw_c[0] = btn_in;
    end
  end

  assign rdata_out = key_ok_out ? raw_c : (raw_c ^ LOCK_MASK);
  assign io_out    = words[DEPTH-1];

endmodule

// File: tb/tb_qtcore_scan_mem_locked.sv
// Directed bench for qtcore_scan_mem_locked: scan load/unload, key lock, processor port, reset.
module tb_qtcore_scan_mem_locked;

  localparam int unsigned CL = 144;
  typedef logic [CL-1:0] chain_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scan_enable = 1'b0;
  logic       scan_in = 1'b0;
  logic       scan_out;
  logic       proc_en = 1'b0;
  logic [3:0] addr = '0;
  logic       we = 1'b0;
  logic [7:0] wdata = '0;
  logic [7:0] rdata;
  logic       btn = 1'b0;
  logic [7:0] io;
  logic       key_ok;
  logic       scan_done;

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;

  qtcore_scan_mem_locked dut (
    .clk_in         (clk),
    .rst_in         (rst),
    .scan_enable_in (scan_enable),
    .scan_in        (scan_in),
    .scan_out       (scan_out),
    .proc_en_in     (proc_en),
    .addr_in        (addr),
    .we_in          (we),
    .wdata_in       (wdata),
    .rdata_out      (rdata),
    .btn_in         (btn),
    .io_out         (io),
    .key_ok_out     (key_ok),
    .scan_done_out  (scan_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (scan_done === 1'b1) done_cnt++;

  task automatic chk(input string tag, input chain_t obs, input chain_t exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the last of CL shifts.
  task automatic scan(input chain_t load, output chain_t unload);
    for (int n = 0; n < CL; n++) begin
      unload[CL-1-n] = scan_out;
      scan_in        = load[CL-1-n];
      scan_enable    = 1'b1;
      @(negedge clk);
    end
  endtask

  function automatic chain_t mk(input logic [15:0] key);
    chain_t c = '0;
    c[0*8  +: 8]  = 8'h3C;
    c[1*8  +: 8]  = 8'hE1;
    c[7*8  +: 8]  = 8'h81;
    c[15*8 +: 8]  = 8'hF0;
    c[128  +: 16] = key;
    return c;
  endfunction

  initial begin
    chain_t l1, l2, u;
    int d0;
    l1 = mk(16'hA5C3);
    l2 = mk(16'h0000);

    // reset state
    @(negedge clk);
    chk("rst_io", chain_t'(io), chain_t'(8'h00));
    chk("rst_key_ok", chain_t'(key_ok), chain_t'(1'b0));
    chk("rst_done", chain_t'(scan_done), chain_t'(1'b0));
    chk("rst_scan_out", chain_t'(scan_out), chain_t'(1'b0));
    chk("rst_rdata_locked", chain_t'(rdata), chain_t'(8'h5A));
    rst = 1'b0;

    // 1: full load with correct key
    d0 = done_cnt;
    scan(l1, u);
    chk("t1_unload", u, chain_t'(0));
    chk("t1_done_end", chain_t'(scan_done), chain_t'(1'b1));
    scan_enable = 1'b0;
    @(negedge clk);
    chk("t1_done_count", chain_t'(done_cnt - d0), chain_t'(1));
    chk("t1_key_ok", chain_t'(key_ok), chain_t'(1'b1));
    chk("t1_io", chain_t'(io), chain_t'(8'hF0));
    addr = 4'd1; #1;
    chk("t1_rdata1", chain_t'(rdata), chain_t'(8'hE1));

    // 2: wrong key locks the read path
    @(negedge clk);
    scan(l2, u);
    chk("t2_unload", u, l1);
    scan_enable = 1'b0;
    @(negedge clk);
    chk("t2_key_ok", chain_t'(key_ok), chain_t'(1'b0));
    addr = 4'd1; #1;
    chk("t2_rdata1_masked", chain_t'(rdata), chain_t'(8'hBB));
    chk("t2_io", chain_t'(io), chain_t'(8'hF0));

    // 3: processor writes, then a write collided with a shift
    @(negedge clk);
    scan(l1, u);
    chk("t3_unload", u, l2);
    scan_enable = 1'b0;
    @(negedge clk);
    chk("t3_key_ok", chain_t'(key_ok), chain_t'(1'b1));
    proc_en = 1'b1; we = 1'b1; addr = 4'd3; wdata = 8'h2F;
    @(negedge clk);
    we = 1'b0; #1;
    chk("t3_write", chain_t'(rdata), chain_t'(8'h2F));
    @(negedge clk);
    proc_en = 1'b0; we = 1'b1; wdata = 8'h77;
    @(negedge clk);
    we = 1'b0; #1;
    chk("t3_no_proc_en", chain_t'(rdata), chain_t'(8'h2F));
    @(negedge clk);
    proc_en = 1'b1; we = 1'b1; wdata = 8'h2F; scan_in = 1'b0; scan_enable = 1'b1;
    @(negedge clk);
    #1;
    chk("t3_scan_wins", chain_t'(rdata), chain_t'(8'h5E));
    chk("t3_io_shifted", chain_t'(io), chain_t'(8'hE0));
    proc_en = 1'b0; we = 1'b0; scan_enable = 1'b0;
    @(negedge clk);
    chk("t3_key_rechecked", chain_t'(key_ok), chain_t'(1'b0));

    // 4: IO register read returns btn in bit0 (locked)
    addr = 4'd15; btn = 1'b0; #1;
    chk("t4_btn0", chain_t'(rdata), chain_t'(8'hBA));
    chk("t4_io0", chain_t'(io), chain_t'(8'hE0));
    btn = 1'b1; #1;
    chk("t4_btn1", chain_t'(rdata), chain_t'(8'hBB));
    chk("t4_io1", chain_t'(io), chain_t'(8'hE0));

    // 5: reset in the middle of a scan
    @(negedge clk);
    btn = 1'b0; addr = 4'd0; scan_in = 1'b1; scan_enable = 1'b1;
    repeat (37) @(negedge clk);
    rst = 1'b1; #1;
    chk("t5_io", chain_t'(io), chain_t'(8'h00));
    chk("t5_key_ok", chain_t'(key_ok), chain_t'(1'b0));
    chk("t5_done", chain_t'(scan_done), chain_t'(1'b0));
    chk("t5_scan_out", chain_t'(scan_out), chain_t'(1'b0));
    chk("t5_rdata", chain_t'(rdata), chain_t'(8'h5A));
    #1;
    rst = 1'b0;
    d0 = done_cnt;
    scan(l1, u);
    chk("t5_unload", u, chain_t'(0));
    chk("t5_done_end", chain_t'(scan_done), chain_t'(1'b1));
    scan_enable = 1'b0;
    @(negedge clk);
    chk("t5_done_count", chain_t'(done_cnt - d0), chain_t'(1));
    chk("t5_key_ok_after", chain_t'(key_ok), chain_t'(1'b1));
    chk("t5_io_after", chain_t'(io), chain_t'(8'hF0));
    addr = 4'd1; #1;
    chk("t5_rdata1", chain_t'(rdata), chain_t'(8'hE1));

    // 6: two back-to-back chain lengths
    @(negedge clk);
    d0 = done_cnt;
    scan(l2, u);
    chk("t6_unload1", u, l1);
    chk("t6_key_held", chain_t'(key_ok), chain_t'(1'b1));
    scan(l2, u);
    chk("t6_unload2", u, l2);
    chk("t6_done_end", chain_t'(scan_done), chain_t'(1'b1));
    scan_enable = 1'b0;
    @(negedge clk);
    chk("t6_done_count", chain_t'(done_cnt - d0), chain_t'(2));
    chk("t6_key_ok", chain_t'(key_ok), chain_t'(1'b0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
